// File: rtl/steer_sched.sv
// Steering scheduler: slews the servo direction code one ladder step per step
// edge toward a target chosen by a TRACK / MANUAL / LOST state machine.
module steer_sched #(
    parameter int PERIOD_US   = 5000,
    parameter int LOST_FRAMES = 40,
    parameter int STEP_FRAMES = 1
) (
    input  logic       clkus,
    input  logic       rst,
    input  logic [2:0] trk_dir,
    input  logic       trk_valid,
    input  logic       man_req,
    input  logic [2:0] man_dir,
    output logic [2:0] direction,
    output logic       man_gnt,
    output logic       frame,
    output logic       at_target,
    output logic       lost,
    output logic [1:0] state_dbg
);

    localparam int FW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int LW = $clog2(LOST_FRAMES + 1);

    typedef enum logic [1:0] {
        S_TRACK  = 2'd0,
        S_MANUAL = 2'd1,
        S_LOST   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [LW-1:0] lost_cnt_q, lost_cnt_d;
    logic [2:0]    latch_q, latch_d;
    logic [2:0]    dir_q, dir_d;
    logic          armed_q, armed_d;

    logic       step_edge, grant, rel;
    logic [2:0] man_dec, cur_tgt, step_tgt, idx_cur, idx_tgt;

    function automatic logic [2:0] decode(input logic [2:0] c);
        case (c)
            3'b000, 3'b001, 3'b011, 3'b101, 3'b111: decode = c;
            default:                                decode = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] to_idx(input logic [2:0] c);
        case (c)
            3'b011:  to_idx = 3'd0;
            3'b001:  to_idx = 3'd1;
            3'b101:  to_idx = 3'd3;
            3'b111:  to_idx = 3'd4;
            default: to_idx = 3'd2;
        endcase
    endfunction

    function automatic logic [2:0] to_code(input logic [2:0] i);
        case (i)
            3'd0:    to_code = 3'b011;
            3'd1:    to_code = 3'b001;
            3'd3:    to_code = 3'b101;
            3'd4:    to_code = 3'b111;
            default: to_code = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clkus or posedge rst) begin
        if (rst) begin
            state_q     <= S_TRACK;
            frame_cnt_q <= '0;
            step_cnt_q  <= '0;
            lost_cnt_q  <= '0;
            latch_q     <= 3'b000;
            dir_q       <= 3'b000;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            step_cnt_q  <= step_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
            latch_q     <= latch_d;
            dir_q       <= dir_d;
            armed_q     <= armed_d;
        end
    end

    // man_req/man_gnt handshake: the grant is taken only on a frame pulse while
    // man_req is high, holds while man_req stays high, and drops on the first
    // edge that sees man_req low. A request seen at reset must go low once first.
    always_comb begin
        frame       = (frame_cnt_q == FW'(PERIOD_US - 1));
        frame_cnt_d = frame ? '0 : frame_cnt_q + FW'(1);
        step_edge   = frame && (step_cnt_q == SW'(STEP_FRAMES - 1));
        step_cnt_d  = step_cnt_q;
        if (frame) step_cnt_d = step_edge ? '0 : step_cnt_q + SW'(1);

        latch_d = trk_valid ? decode(trk_dir) : latch_q;
        armed_d = armed_q | ~man_req;
        man_dec = decode(man_dir);

        grant = (state_q != S_MANUAL) && frame && man_req && armed_q;
        rel   = (state_q == S_MANUAL) && !man_req;

        lost_cnt_d = lost_cnt_q;
        if (trk_valid) lost_cnt_d = '0;
        else if (frame && lost_cnt_q != LW'(LOST_FRAMES)) lost_cnt_d = lost_cnt_q + LW'(1);
        if (rel) lost_cnt_d = '0;

        state_d = state_q;
        case (state_q)
            S_TRACK: begin
                if (grant) state_d = S_MANUAL;
                else if (lost_cnt_d == LW'(LOST_FRAMES)) state_d = S_LOST;
            end
            S_MANUAL: if (rel) state_d = S_TRACK;
            S_LOST: begin
                if (grant) state_d = S_MANUAL;
                else if (trk_valid) state_d = S_TRACK;
            end
            default: state_d = S_TRACK;
        endcase

        case (state_q)
            S_MANUAL: cur_tgt = man_dec;
            S_LOST:   cur_tgt = 3'b000;
            default:  cur_tgt = latch_q;
        endcase

        // A grant edge steps toward the manoeuvre target; a release edge still uses it.
        step_tgt = (state_q == S_MANUAL || grant) ? man_dec : cur_tgt;
        idx_cur  = to_idx(dir_q);
        idx_tgt  = to_idx(step_tgt);
        dir_d    = dir_q;
        if (step_edge) begin
            if (idx_cur < idx_tgt) dir_d = to_code(idx_cur + 3'd1);
            else if (idx_cur > idx_tgt) dir_d = to_code(idx_cur - 3'd1);
        end
    end

    assign direction = dir_q;
    assign man_gnt   = (state_q == S_MANUAL);
    assign lost      = (state_q == S_LOST);
    assign at_target = (dir_q == cur_tgt);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_steer_sched.sv
// Bench for steer_sched: two instances (one and two frames per step) checked
// every cycle against a ladder-index model, plus directed scenario checks.
module tb_steer_sched;

    localparam int P = 8;
    localparam int L = 40;

    logic       clkus = 1'b0;
    logic       rst;
    logic [2:0] trk_dir, man_dir;
    logic       trk_valid, man_req;

    logic [2:0] d1_dir, d2_dir;
    logic       d1_gnt, d2_gnt, d1_frame, d2_frame, d1_at, d2_at, d1_lost, d2_lost;
    logic [1:0] d1_st, d2_st;

    always #5 clkus = ~clkus;

    steer_sched #(.PERIOD_US(P), .LOST_FRAMES(L), .STEP_FRAMES(1)) dut1 (
        .clkus(clkus), .rst(rst), .trk_dir(trk_dir), .trk_valid(trk_valid),
        .man_req(man_req), .man_dir(man_dir), .direction(d1_dir), .man_gnt(d1_gnt),
        .frame(d1_frame), .at_target(d1_at), .lost(d1_lost), .state_dbg(d1_st));

    steer_sched #(.PERIOD_US(P), .LOST_FRAMES(L), .STEP_FRAMES(2)) dut2 (
        .clkus(clkus), .rst(rst), .trk_dir(trk_dir), .trk_valid(trk_valid),
        .man_req(man_req), .man_dir(man_dir), .direction(d2_dir), .man_gnt(d2_gnt),
        .frame(d2_frame), .at_target(d2_at), .lost(d2_lost), .state_dbg(d2_st));

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: position in time, frames seen, mode name and ladder index.
    logic [2:0] ladder [5] = '{3'b011, 3'b001, 3'b000, 3'b101, 3'b111};
    int         m_cyc, m_frames, m_mode, m_lost;  // mode 0 track, 1 manual, 2 lost
    logic [2:0] m_latch;
    bit         m_armed;
    int         m_idx [2];
    int         sf    [2] = '{1, 2};

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] dec(input logic [2:0] c);
        return (c == 3'b000 || c == 3'b001 || c == 3'b011 || c == 3'b101 || c == 3'b111) ? c : 3'b000;
    endfunction

    function automatic int idx_of(input logic [2:0] c);
        for (int i = 0; i < 5; i++) if (ladder[i] == dec(c)) return i;
        return 2;
    endfunction

    function automatic logic [2:0] m_target();
        if (m_mode == 1) return dec(man_dir);
        if (m_mode == 2) return 3'b000;
        return m_latch;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_frames = 0; m_mode = 0; m_lost = 0;
        m_latch = 3'b000; m_armed = 1'b0;
        m_idx[0] = 2; m_idx[1] = 2;
    endtask

    task automatic model_step();
        bit is_frame, grant, rel;
        int tgt;
        is_frame = (m_cyc % P) == P - 1;
        grant    = (m_mode != 1) && is_frame && man_req && m_armed;
        rel      = (m_mode == 1) && !man_req;
        tgt      = (m_mode == 1 || grant) ? idx_of(man_dir) : idx_of(m_target());
        for (int k = 0; k < 2; k++)
            if (is_frame && (m_frames % sf[k]) == sf[k] - 1) begin
                if (m_idx[k] < tgt) m_idx[k]++;
                else if (m_idx[k] > tgt) m_idx[k]--;
            end
        if (trk_valid) m_lost = 0;
        else if (is_frame && m_lost < L) m_lost++;
        if (rel) m_lost = 0;
        if (grant) m_mode = 1;
        else if (rel) m_mode = 0;
        else if (m_mode == 0 && m_lost == L) m_mode = 2;
        else if (m_mode == 2 && trk_valid) m_mode = 0;
        if (trk_valid) m_latch = dec(trk_dir);
        if (!man_req) m_armed = 1'b1;
        if (is_frame) m_frames++;
        m_cyc++;
    endtask

    task automatic check_all();
        bit fr;
        fr = (m_cyc % P) == P - 1;
        check("d1_direction", d1_dir, ladder[m_idx[0]]);
        check("d2_direction", d2_dir, ladder[m_idx[1]]);
        check("d1_man_gnt", {2'b0, d1_gnt}, {2'b0, m_mode == 1});
        check("d2_man_gnt", {2'b0, d2_gnt}, {2'b0, m_mode == 1});
        check("d1_frame", {2'b0, d1_frame}, {2'b0, fr});
        check("d2_frame", {2'b0, d2_frame}, {2'b0, fr});
        check("d1_lost", {2'b0, d1_lost}, {2'b0, m_mode == 2});
        check("d2_lost", {2'b0, d2_lost}, {2'b0, m_mode == 2});
        check("d1_at_target", {2'b0, d1_at}, {2'b0, ladder[m_idx[0]] == m_target()});
        check("d2_at_target", {2'b0, d2_at}, {2'b0, ladder[m_idx[1]] == m_target()});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkus);
            model_step();
            @(negedge clkus);
            check_all();
        end
    endtask

    initial begin
        rst = 1'b1; trk_dir = 3'b000; trk_valid = 1'b0; man_req = 1'b0; man_dir = 3'b000;
        model_reset();
        #1;
        check("rst_direction", d1_dir, 3'b000);
        check("rst_man_gnt", {2'b0, d1_gnt}, 3'b000);
        check("rst_frame", {2'b0, d1_frame}, 3'b000);
        check("rst_lost", {2'b0, d1_lost}, 3'b000);
        @(negedge clkus);
        rst = 1'b0; trk_dir = 3'b111; trk_valid = 1'b1;

        // Slew to RIGHT_BIG: one step per frame, or per two frames on dut2.
        tick(P - 1);
        check("first_frame_pulse", {2'b0, d1_frame}, 3'b001);
        tick(1);
        check("s1_frame1", d1_dir, 3'b101);
        check("s2_frame1_hold", d2_dir, 3'b000);
        tick(P);
        check("s1_frame2", d1_dir, 3'b111);
        check("s1_at_target", {2'b0, d1_at}, 3'b001);
        check("s2_frame2", d2_dir, 3'b101);
        tick(P);
        check("s2_frame3_hold", d2_dir, 3'b101);
        tick(P);
        check("s2_frame4", d2_dir, 3'b111);

        // Tracker goes silent for LOST_FRAMES frames.
        trk_valid = 1'b0;
        tick(L * P - 1);
        check("lost_not_yet", {2'b0, d1_lost}, 3'b000);
        tick(1);
        check("lost_at_frame_L", {2'b0, d1_lost}, 3'b001);
        check("lost_dir_hold", d1_dir, 3'b111);
        tick(P);
        check("lost_step1", d1_dir, 3'b101);
        tick(P);
        check("lost_step2", d1_dir, 3'b000);
        trk_valid = 1'b1; trk_dir = 3'b001;
        tick(1);
        check("lost_recover", {2'b0, d1_lost}, 3'b000);
        trk_valid = 1'b0;

        // Manoeuvre request mid-frame, grant on the next frame pulse.
        man_req = 1'b1; man_dir = 3'b011;
        tick(P - 2);
        check("gnt_before_frame", {2'b0, d1_gnt}, 3'b000);
        tick(1);
        check("gnt_rise", {2'b0, d1_gnt}, 3'b001);
        check("gnt_step_uses_man", d1_dir, 3'b001);
        tick(P);
        check("man_reach", d1_dir, 3'b011);
        man_req = 1'b0;
        tick(1);
        check("gnt_fall", {2'b0, d1_gnt}, 3'b000);
        tick(P);
        check("back_to_track", d1_dir, 3'b001);

        // Short request between frames is abandoned; invalid code is STRAIGHT.
        man_req = 1'b1;
        tick(3);
        man_req = 1'b0;
        tick(P);
        check("short_req_no_gnt", {2'b0, d1_gnt}, 3'b000);
        trk_dir = 3'b010; trk_valid = 1'b1;
        tick(2 * P);
        check("invalid_is_straight", d1_dir, 3'b000);
        check("invalid_at_target", {2'b0, d1_at}, 3'b001);

        // Asynchronous reset in the middle of a manoeuvre.
        man_req = 1'b1; man_dir = 3'b111;
        tick(4 * P);
        check("pre_rst_dir", d1_dir, 3'b111);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_dir", d1_dir, 3'b000);
        check("async_rst_gnt", {2'b0, d1_gnt}, 3'b000);
        man_req = 1'b0;
        @(negedge clkus);
        rst = 1'b0;

        // Randomized traffic, with some long tracker dropouts.
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 350; c++) begin
                trk_valid = (seg == 2 || seg == 4) ? 1'b0 : ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) trk_dir = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 19) == 0) man_req = ~man_req;
                if ($urandom_range(0, 9) == 0) man_dir = 3'($urandom_range(0, 7));
                tick(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
